systolic_sequencer: RTL

//  Control FSM for the 3x3 systolic convolution array. Replaces the free-running

---
 rtl/systolic_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/systolic_sequencer.sv
// Start/busy/done control FSM for the 3x3 systolic convolution array: feed-mux step, PE mode,
// PE clock enable and output-shift enable. Optional run-cycle counter under SYSTOLIC_SEQ_CYCLE_CNT_EN.
module systolic_sequencer #(
  parameter int FEED_CYCLES  = 11,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [CNT_W-1:0] step,
  output logic             feed_en,
  output logic             mode,
  output logic             pe_en,
  output logic             cap_en,
  output logic             busy,
  output logic             done
`ifdef SYSTOLIC_SEQ_CYCLE_CNT_EN
  ,
  output logic [7:0]       run_cycles
`endif
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     step_q, step_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 feed_en_q, feed_en_d;
  logic                 mode_q, mode_d;
  logic                 pe_en_q, pe_en_d;
  logic                 cap_en_q, cap_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_acc;

  function automatic logic [CNT_W-1:0] sat_inc_step(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [DRAIN_W-1:0] sat_inc_drain(input logic [DRAIN_W-1:0] v);
    return (v == {DRAIN_W{1'b1}}) ? v : v + DRAIN_W'(1);
  endfunction

  // abort in IDLE/DONE only masks a same-cycle start
  assign start_acc = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      drain_q   <= '0;
      feed_en_q <= 1'b0;
      mode_q    <= 1'b1;
      pe_en_q   <= 1'b0;
      cap_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      drain_q   <= drain_d;
      feed_en_q <= feed_en_d;
      mode_q    <= mode_d;
      pe_en_q   <= pe_en_d;
      cap_en_q  <= cap_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = '0;
    drain_d = '0;
    unique case (state_q)
      IDLE, DONE: state_d = start_acc ? FEED : IDLE;
      FEED: begin
        if (abort)                                   state_d = IDLE;
        else if (step_q == CNT_W'(FEED_CYCLES - 1))  state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                                       state_d = IDLE;
        else if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1))  state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Counters follow the destination state; DRAIN parks step on the zero slot.
    unique case (state_d)
      FEED:    step_d = (state_q == FEED) ? sat_inc_step(step_q) : '0;
      DRAIN: begin
        step_d  = CNT_W'(FEED_CYCLES);
        drain_d = (state_q == DRAIN) ? sat_inc_drain(drain_q) : '0;
      end
      default: begin
        step_d  = '0;
        drain_d = '0;
      end
    endcase
  end

  always_comb begin
    feed_en_d = (state_d == FEED);
    mode_d    = (state_d != FEED);
    pe_en_d   = (state_d == FEED) || (state_d == DRAIN);
    cap_en_d  = (state_d == DRAIN);
    busy_d    = (state_d == FEED) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
  end

  assign step    = step_q;
  assign feed_en = feed_en_q;
  assign mode    = mode_q;
  assign pe_en   = pe_en_q;
  assign cap_en  = cap_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SYSTOLIC_SEQ_CYCLE_CNT_EN
  logic [7:0] run_cycles_q;

  // Counts every cycle pe_en was high; idles (and thus freezes) once pe_en drops.
  always_ff @(posedge clk) begin
    if (!rst)                                    run_cycles_q <= '0;
    else if (start_acc)                          run_cycles_q <= '0;
    else if (pe_en_q && run_cycles_q != 8'hFF)   run_cycles_q <= run_cycles_q + 8'd1;
  end

  assign run_cycles = run_cycles_q;
`endif

endmodule
